// File: rtl/ldlt_tri_buffer_pkg.sv
// Shared constants and size helpers for the lower-triangular stream buffer.
package ldlt_tri_buffer_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_FULL = 2'd2;
  localparam logic [1:0] ST_READ = 2'd3;

  localparam logic ROW_MAJOR = 1'b0;
  localparam logic COL_MAJOR = 1'b1;

  // Matrix dimension: six degrees of freedom per node.
  function automatic int dim(input int node_num);
    return 6 * node_num;
  endfunction

  // Number of stored elements of the packed lower triangle.
  function automatic int l_size(input int node_num);
    int d;
    d = 6 * node_num;
    return d * (d + 1) / 2;
  endfunction

endpackage

// File: rtl/ldlt_tri_buffer_if.sv
// Load stream, replay stream and status bundle of the triangular buffer.
interface ldlt_tri_buffer_if #(
  parameter int DATA_LEN = 32,
  parameter int NODE_NUM = 1
);
  import ldlt_tri_buffer_pkg::*;

  localparam int IDX_W = $clog2(dim(NODE_NUM));

  logic                i_start;
  logic                i_valid;
  logic [DATA_LEN-1:0] i_data;
  logic                o_in_ready;
  logic                i_rd_start;
  logic                i_mode;
  logic                o_valid;
  logic [DATA_LEN-1:0] o_data;
  logic [IDX_W-1:0]    o_row;
  logic [IDX_W-1:0]    o_col;
  logic                o_last;
  logic                i_out_ready;
  logic                o_loaded;
  logic                o_err;

  modport master (
    output i_start, i_valid, i_data, i_rd_start, i_mode, i_out_ready,
    input  o_in_ready, o_valid, o_data, o_row, o_col, o_last, o_loaded, o_err
  );

  modport slave (
    input  i_start, i_valid, i_data, i_rd_start, i_mode, i_out_ready,
    output o_in_ready, o_valid, o_data, o_row, o_col, o_last, o_loaded, o_err
  );

endinterface

// File: rtl/ldlt_tri_buffer_mem.sv
// Simple dual-port storage for the packed triangle: one write, one registered read.
module ldlt_tri_mem #(
  parameter int DATA_LEN = 32,
  parameter int DEPTH    = 21,
  parameter int ADDR_W   = 5
) (
  input  logic                clk,
  input  logic                we,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [DATA_LEN-1:0] wdata,
  input  logic                re,
  input  logic [ADDR_W-1:0]   raddr,
  output logic [DATA_LEN-1:0] rdata
);

  logic [DATA_LEN-1:0] mem [DEPTH];

  // Contents are never cleared; read data is held between read enables.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/ldlt_tri_buffer.sv
// Stream-in / stream-out buffer for a packed lower-triangular matrix.
//
//  state | meaning
//  IDLE  | nothing held, waiting for a load
//  LOAD  | accepting elements in packed row-major order
//  FULL  | whole triangle held, replay or reload allowed
//  READ  | replaying row-major or column-major with coordinates
module ldlt_tri_buffer
  import ldlt_tri_buffer_pkg::*;
#(
  parameter int DATA_LEN = 32,
  parameter int NODE_NUM = 1,
  parameter int FRACTION = 16
) (
  input logic            clk,
  input logic            rst,
  ldlt_tri_buffer_if.slave bus
);

  localparam int DIM    = dim(NODE_NUM);
  localparam int L_SIZE = l_size(NODE_NUM);
  localparam int IDX_W  = $clog2(DIM);
  localparam int ADDR_W = $clog2(L_SIZE);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DIM - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(L_SIZE - 1);

  // FRACTION only describes the data format; data passes through untouched.
  logic unused_frac;
  assign unused_frac = ^FRACTION;

  logic [1:0]          state;
  logic [ADDR_W-1:0]   wr_addr;
  logic                loaded;
  logic                err;
  logic                in_ready;
  logic                wr_en;
  logic                rd_go;

  logic [ADDR_W-1:0]   g_addr;
  logic [ADDR_W-1:0]   g_cstart;
  logic [ADDR_W-1:0]   next_cstart;
  logic [IDX_W-1:0]    g_row;
  logic [IDX_W-1:0]    g_col;
  logic                g_mode;
  logic                g_done;
  logic                g_last;
  logic                issue;

  logic                p_valid;
  logic [IDX_W-1:0]    p_row;
  logic [IDX_W-1:0]    p_col;
  logic                p_last;
  logic [DATA_LEN-1:0] rd_data;

  logic [DATA_LEN-1:0] f_data [2];
  logic [IDX_W-1:0]    f_row  [2];
  logic [IDX_W-1:0]    f_col  [2];
  logic                f_last [2];
  logic [1:0]          f_cnt;
  logic                push;
  logic                pop;
  logic                wr_hi;

  logic                out_valid;
  logic [DATA_LEN-1:0] out_data;
  logic [IDX_W-1:0]    out_row;
  logic [IDX_W-1:0]    out_col;
  logic                out_last;
  logic                accept;

  assign in_ready = (state == ST_LOAD);
  assign wr_en    = in_ready && bus.i_valid;
  assign rd_go    = (state == ST_FULL) && bus.i_rd_start && !bus.i_start;
  assign accept   = out_valid && bus.i_out_ready;

  // Issue a read only when the element cannot overflow the skid buffer:
  // at most one word may sit between memory output and skid entries.
  assign issue  = (state == ST_READ) && !g_done &&
                  ((f_cnt == 2'd0) || ((f_cnt == 2'd1) && !p_valid));
  assign g_last = (g_row == LAST_IDX) && (g_col == LAST_IDX);
  // Column c starts at c*(c+3)/2; consecutive starts differ by c+2.
  assign next_cstart = g_cstart + ADDR_W'(g_col) + ADDR_W'(2);

  // Sequencing between load, hold and replay.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      wr_addr <= '0;
      loaded  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.i_start) begin
            state   <= ST_LOAD;
            wr_addr <= '0;
          end
        end
        ST_LOAD: begin
          if (wr_en) begin
            wr_addr <= wr_addr + ADDR_W'(1);
            if (wr_addr == LAST_ADDR) begin
              state  <= ST_FULL;
              loaded <= 1'b1;
            end
          end
        end
        ST_FULL: begin
          if (bus.i_start) begin
            state   <= ST_LOAD;
            wr_addr <= '0;
            loaded  <= 1'b0;
          end else if (bus.i_rd_start) begin
            state <= ST_READ;
          end
        end
        default: begin
          if (accept && out_last) state <= ST_FULL;
        end
      endcase
    end
  end

  // Sticky protocol error: control pulses while busy, data outside a load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else begin
      if ((bus.i_start || bus.i_rd_start) &&
          ((state == ST_LOAD) || (state == ST_READ)))
        err <= 1'b1;
      if (bus.i_valid && !in_ready && !((state == ST_FULL) && bus.i_start))
        err <= 1'b1;
    end
  end

  // Read address generator; column-major walks addresses by additions only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      g_addr   <= '0;
      g_cstart <= '0;
      g_row    <= '0;
      g_col    <= '0;
      g_mode   <= ROW_MAJOR;
      g_done   <= 1'b0;
    end else if (rd_go) begin
      g_addr   <= '0;
      g_cstart <= '0;
      g_row    <= '0;
      g_col    <= '0;
      g_mode   <= bus.i_mode;
      g_done   <= 1'b0;
    end else if (issue) begin
      if (g_last) begin
        g_done <= 1'b1;
      end else if (g_mode == ROW_MAJOR) begin
        g_addr <= g_addr + ADDR_W'(1);
        if (g_col == g_row) begin
          g_row <= g_row + IDX_W'(1);
          g_col <= '0;
        end else begin
          g_col <= g_col + IDX_W'(1);
        end
      end else if (g_row == LAST_IDX) begin
        g_col    <= g_col + IDX_W'(1);
        g_row    <= g_col + IDX_W'(1);
        g_cstart <= next_cstart;
        g_addr   <= next_cstart;
      end else begin
        g_row  <= g_row + IDX_W'(1);
        g_addr <= g_addr + ADDR_W'(g_row) + ADDR_W'(1);
      end
    end
  end

  // Coordinates travel alongside the memory read so they line up with rd_data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_valid <= 1'b0;
      p_row   <= '0;
      p_col   <= '0;
      p_last  <= 1'b0;
    end else begin
      p_valid <= issue;
      if (issue) begin
        p_row  <= g_row;
        p_col  <= g_col;
        p_last <= g_last;
      end
    end
  end

  ldlt_tri_mem #(
    .DATA_LEN(DATA_LEN),
    .DEPTH   (L_SIZE),
    .ADDR_W  (ADDR_W)
  ) u_mem (
    .clk  (clk),
    .we   (wr_en),
    .waddr(wr_addr),
    .wdata(bus.i_data),
    .re   (issue),
    .raddr(g_addr),
    .rdata(rd_data)
  );

  assign push  = p_valid && !((f_cnt == 2'd0) && accept);
  assign pop   = (f_cnt != 2'd0) && accept;
  assign wr_hi = (f_cnt == 2'd2) || ((f_cnt == 2'd1) && !pop);

  // Two-entry skid: catches a read word whenever it is not taken directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_cnt <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        f_data[i] <= '0;
        f_row[i]  <= '0;
        f_col[i]  <= '0;
        f_last[i] <= 1'b0;
      end
    end else begin
      if (pop) begin
        f_data[0] <= f_data[1];
        f_row[0]  <= f_row[1];
        f_col[0]  <= f_col[1];
        f_last[0] <= f_last[1];
      end
      if (push) begin
        if (wr_hi) begin
          f_data[1] <= rd_data;
          f_row[1]  <= p_row;
          f_col[1]  <= p_col;
          f_last[1] <= p_last;
        end else begin
          f_data[0] <= rd_data;
          f_row[0]  <= p_row;
          f_col[0]  <= p_col;
          f_last[0] <= p_last;
        end
      end
      f_cnt <= f_cnt + {1'b0, push} - {1'b0, pop};
    end
  end

  // Present the oldest element: skid head first, else the fresh memory word.
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_row   = '0;
    out_col   = '0;
    out_last  = 1'b0;
    if (f_cnt != 2'd0) begin
      out_valid = 1'b1;
      out_data  = f_data[0];
      out_row   = f_row[0];
      out_col   = f_col[0];
      out_last  = f_last[0];
    end else if (p_valid) begin
      out_valid = 1'b1;
      out_data  = rd_data;
      out_row   = p_row;
      out_col   = p_col;
      out_last  = p_last;
    end
  end

  assign bus.o_in_ready = in_ready;
  assign bus.o_valid    = out_valid;
  assign bus.o_data     = out_data;
  assign bus.o_row      = out_row;
  assign bus.o_col      = out_col;
  assign bus.o_last     = out_last;
  assign bus.o_loaded   = loaded;
  assign bus.o_err      = err;

endmodule

// File: tb/tb_ldlt_tri_buffer.sv
// Directed bench for the triangular buffer: one-node and two-node instances.
module tb_ldlt_tri_buffer;

  typedef struct {
    logic [31:0] data;
    int          row;
    int          col;
    logic        last;
  } vec_t;

  typedef struct {
    int mode;
    int rdy_pct;
  } scn_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  ldlt_tri_buffer_if #(.DATA_LEN(32), .NODE_NUM(1)) b1 ();
  ldlt_tri_buffer_if #(.DATA_LEN(32), .NODE_NUM(2)) b2 ();

  ldlt_tri_buffer #(.DATA_LEN(32), .NODE_NUM(1), .FRACTION(16)) dut1 (
    .clk(clk), .rst(rst), .bus(b1));
  ldlt_tri_buffer #(.DATA_LEN(32), .NODE_NUM(2), .FRACTION(16)) dut2 (
    .clk(clk), .rst(rst), .bus(b2));

  logic        st[2], vl[2], rs[2], md[2], ordy[2];
  logic [31:0] dat[2];
  logic        ov[2], ol[2], oir[2], old[2], oer[2];
  logic [31:0] od[2];
  logic [3:0]  orow[2], ocol[2];

  assign b1.i_start = st[0];   assign b2.i_start = st[1];
  assign b1.i_valid = vl[0];   assign b2.i_valid = vl[1];
  assign b1.i_data = dat[0];   assign b2.i_data = dat[1];
  assign b1.i_rd_start = rs[0]; assign b2.i_rd_start = rs[1];
  assign b1.i_mode = md[0];    assign b2.i_mode = md[1];
  assign b1.i_out_ready = ordy[0]; assign b2.i_out_ready = ordy[1];

  assign ov[0] = b1.o_valid;   assign ov[1] = b2.o_valid;
  assign od[0] = b1.o_data;    assign od[1] = b2.o_data;
  assign orow[0] = {1'b0, b1.o_row}; assign orow[1] = b2.o_row;
  assign ocol[0] = {1'b0, b1.o_col}; assign ocol[1] = b2.o_col;
  assign ol[0] = b1.o_last;    assign ol[1] = b2.o_last;
  assign oir[0] = b1.o_in_ready; assign oir[1] = b2.o_in_ready;
  assign old[0] = b1.o_loaded; assign old[1] = b2.o_loaded;
  assign oer[0] = b1.o_err;    assign oer[1] = b2.o_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // {valid, data, row, col, last, in_ready, loaded, err}
  function automatic logic [63:0] outs(input int s);
    return 64'({ov[s], od[s], orow[s], ocol[s], ol[s], oir[s], old[s], oer[s]});
  endfunction

  // Expected replay sequence; one-node column-major data is hand-listed.
  task automatic build(input int d, input int mode);
    int m1[21] = '{1, 2, 4, 7, 11, 16, 3, 5, 8, 12, 17, 6, 9, 13, 18, 10, 14, 19, 15, 20, 21};
    vec_t v;
    int k;
    k = 0;
    tbl.delete();
    if (mode == 0) begin
      for (int r = 0; r < d; r++)
        for (int c = 0; c <= r; c++) begin
          v.data = 32'(k + 1); v.row = r; v.col = c;
          v.last = (r == d - 1) && (c == d - 1);
          tbl.push_back(v); k++;
        end
    end else begin
      for (int c = 0; c < d; c++)
        for (int r = c; r < d; r++) begin
          v.data = (d == 6) ? 32'(m1[k]) : 32'(r * (r + 1) / 2 + c + 1);
          v.row = r; v.col = c;
          v.last = (r == d - 1) && (c == d - 1);
          tbl.push_back(v); k++;
        end
    end
  endtask

  task automatic load(input int s, input int n, input int gap_pct, input int start_at);
    int   k, budget;
    logic v, rdy;
    bit   injected;
    @(negedge clk); st[s] = 1'b1;
    @(negedge clk); st[s] = 1'b0;
    chk("load_entry in_ready,loaded", 64'({oir[s], old[s]}), 64'(2'b10));
    k = 0; budget = 0; injected = 0;
    while (k < n && budget < 2000) begin
      v = ($urandom_range(99) >= gap_pct);
      vl[s] = v; dat[s] = 32'(k + 1); rdy = oir[s];
      if (k == start_at && !injected) begin st[s] = 1'b1; injected = 1; end
      @(negedge clk); st[s] = 1'b0; budget++;
      if (v && rdy) k++;
    end
    vl[s] = 1'b0;
    chk("load_beats", 64'(k), 64'(n));
    chk("load_done in_ready,loaded", 64'({oir[s], old[s]}), 64'(2'b01));
  endtask

  task automatic replay(input int s, input int mode, input int rdy_pct, input int n,
                        input int abort_at);
    int   k, budget;
    logic r;
    @(negedge clk); rs[s] = 1'b1; md[s] = mode[0];
    @(negedge clk); rs[s] = 1'b0; ordy[s] = 1'b0;
    chk("latency_edge1 o_valid", 64'(ov[s]), 64'(0));
    @(negedge clk);
    chk("latency_edge2 o_valid", 64'(ov[s]), 64'(1));
    k = 0; budget = 0;
    while (k < n && k != abort_at && budget < 2000) begin
      r = ($urandom_range(99) < rdy_pct);
      ordy[s] = r;
      if (ov[s]) begin
        chk($sformatf("elem%0d mode%0d data,row,col,last", k, mode),
            64'({od[s], orow[s], ocol[s], ol[s]}),
            64'({tbl[k].data, 4'(tbl[k].row), 4'(tbl[k].col), tbl[k].last}));
        if (r) k++;
      end
      @(negedge clk); budget++;
    end
    ordy[s] = 1'b0;
    if (abort_at < 0) begin
      chk("replay_count", 64'(k), 64'(n));
      chk("replay_end o_valid,loaded", 64'({ov[s], old[s]}), 64'(2'b01));
    end
  endtask

  initial begin
    scn_t scn[4] = '{'{0, 100}, '{1, 100}, '{0, 50}, '{1, 50}};
    for (int i = 0; i < 2; i++) begin
      st[i] = 0; vl[i] = 0; rs[i] = 0; md[i] = 0; ordy[i] = 0; dat[i] = '0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs_n1", outs(0), 64'(0));
    chk("reset_outputs_n2", outs(1), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    rs[0] = 1'b1; @(negedge clk); rs[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_rd_start_ignored", outs(0), 64'(0));

    load(0, 21, 0, -1);
    chk("err_clean_after_load", 64'(oer[0]), 64'(0));
    for (int i = 0; i < 4; i++) begin
      build(6, scn[i].mode);
      replay(0, scn[i].mode, scn[i].rdy_pct, 21, -1);
    end
    chk("err_clean_after_replays", 64'(oer[0]), 64'(0));

    load(0, 21, 40, 10);
    chk("err_after_start_mid_load", 64'(oer[0]), 64'(1));
    build(6, 0);
    replay(0, 0, 50, 21, -1);
    replay(0, 0, 100, 21, -1);

    load(1, 78, 0, -1);
    for (int m = 0; m < 2; m++) begin
      build(12, m);
      replay(1, m, 70, 78, -1);
    end
    chk("n2_err_clean", 64'(oer[1]), 64'(0));

    build(6, 0);
    replay(0, 0, 100, 21, 7);
    rst = 1'b1;
    @(negedge clk);
    chk("reset_mid_replay_outputs", outs(0), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    rs[0] = 1'b1; md[0] = 1'b0;
    @(negedge clk); rs[0] = 1'b0;
    repeat (4) @(negedge clk);
    chk("rd_start_after_reset_ignored", outs(0), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
